// File: rtl/sdram_arbiter_pkg.sv
// Shared types for the two-client SDRAM arbiter: FSM encoding and client write fields.
package sdram_arbiter_pkg;
    localparam int DATA_W = 16;
    localparam int MASK_W = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_A  = 2'd1,
        BUSY_B  = 2'd2,
        RELEASE = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] wr_data;
        logic [MASK_W-1:0] wr_mask;
        logic              we;
    } wr_fields_t;
endpackage

// File: rtl/sdram_arb_mux.sv
// Registered 2:1 selector: captures the winning client's request fields on load.
module sdram_arb_mux
    import sdram_arbiter_pkg::*;
#(
    parameter int ADDR_BITS = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 load_i,
    input  logic                 sel_b_i,
    input  logic [ADDR_BITS-1:0] a_addr_i,
    input  logic [ADDR_BITS-1:0] b_addr_i,
    input  wr_fields_t           a_fields_i,
    input  wr_fields_t           b_fields_i,
    output logic [ADDR_BITS-1:0] ctl_addr_o,
    output logic [DATA_W-1:0]    ctl_wr_data_o,
    output logic [MASK_W-1:0]    ctl_wr_mask_o,
    output logic                 ctl_we_o
);
    logic [ADDR_BITS-1:0] addr_q;
    wr_fields_t           fields_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr_q   <= '0;
            fields_q <= '0;
        end else if (load_i) begin
            addr_q   <= sel_b_i ? b_addr_i   : a_addr_i;
            fields_q <= sel_b_i ? b_fields_i : a_fields_i;
        end
    end

    assign ctl_addr_o    = addr_q;
    assign ctl_wr_data_o = fields_q.wr_data;
    assign ctl_wr_mask_o = fields_q.wr_mask;
    assign ctl_we_o      = fields_q.we;
endmodule

// File: rtl/sdram_arbiter.sv
// Two-client SDRAM request arbiter: A has fixed priority, a wait counter bounds B starvation.
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int ADDR_BITS    = 32,
    parameter int B_WAIT_LIMIT = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic [ADDR_BITS-1:0] a_addr_i,
    input  logic [DATA_W-1:0]    a_wr_data_i,
    input  logic [MASK_W-1:0]    a_wr_mask_i,
    input  logic                 a_we_i,
    input  logic                 a_enable_i,
    output logic                 a_ack_o,
    output logic [DATA_W-1:0]    a_rd_data_o,
    output logic                 a_idle_o,
    input  logic [ADDR_BITS-1:0] b_addr_i,
    input  logic [DATA_W-1:0]    b_wr_data_i,
    input  logic [MASK_W-1:0]    b_wr_mask_i,
    input  logic                 b_we_i,
    input  logic                 b_enable_i,
    output logic                 b_ack_o,
    output logic [DATA_W-1:0]    b_rd_data_o,
    output logic                 b_idle_o,
    output logic [ADDR_BITS-1:0] ctl_addr_o,
    output logic [DATA_W-1:0]    ctl_wr_data_o,
    output logic [MASK_W-1:0]    ctl_wr_mask_o,
    output logic                 ctl_we_o,
    output logic                 ctl_enable_o,
    input  logic [DATA_W-1:0]    ctl_rd_data_i,
    input  logic                 ctl_ack_i,
    input  logic                 ctl_idle_i
);
    localparam logic [7:0] WAIT_MAX = 8'(B_WAIT_LIMIT);

    arb_state_e        state_q;
    logic              granted_b_q;
    logic              ctl_enable_q;
    logic              a_ack_q, b_ack_q;
    logic [DATA_W-1:0] a_rd_q, b_rd_q;
    logic [7:0]        b_wait_q;

    logic load_d, grant_b_d, granted_en_d;

    assign grant_b_d    = b_enable_i && (!a_enable_i || b_wait_q == WAIT_MAX);
    assign load_d       = (state_q == IDLE) && ctl_idle_i && (a_enable_i || b_enable_i);
    assign granted_en_d = granted_b_q ? b_enable_i : a_enable_i;

    sdram_arb_mux #(.ADDR_BITS(ADDR_BITS)) u_mux (
        .clk_i        (clk_i),
        .rst_n_i      (reset_n_i),
        .load_i       (load_d),
        .sel_b_i      (grant_b_d),
        .a_addr_i     (a_addr_i),
        .b_addr_i     (b_addr_i),
        .a_fields_i   ('{wr_data: a_wr_data_i, wr_mask: a_wr_mask_i, we: a_we_i}),
        .b_fields_i   ('{wr_data: b_wr_data_i, wr_mask: b_wr_mask_i, we: b_we_i}),
        .ctl_addr_o   (ctl_addr_o),
        .ctl_wr_data_o(ctl_wr_data_o),
        .ctl_wr_mask_o(ctl_wr_mask_o),
        .ctl_we_o     (ctl_we_o)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            granted_b_q  <= 1'b0;
            ctl_enable_q <= 1'b0;
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            a_rd_q       <= '0;
            b_rd_q       <= '0;
            b_wait_q     <= '0;
        end else begin
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            case (state_q)
                IDLE: if (load_d) begin
                    ctl_enable_q <= 1'b1;
                    granted_b_q  <= grant_b_d;
                    if (grant_b_d) begin
                        state_q  <= BUSY_B;
                        b_wait_q <= '0;
                    end else begin
                        state_q <= BUSY_A;
                        if (b_enable_i && b_wait_q < WAIT_MAX) b_wait_q <= b_wait_q + 8'd1;
                    end
                end
                BUSY_A: if (ctl_ack_i) begin
                    ctl_enable_q <= 1'b0;
                    a_ack_q      <= 1'b1;
                    a_rd_q       <= ctl_rd_data_i;
                    state_q      <= RELEASE;
                end
                BUSY_B: if (ctl_ack_i) begin
                    ctl_enable_q <= 1'b0;
                    b_ack_q      <= 1'b1;
                    b_rd_q       <= ctl_rd_data_i;
                    state_q      <= RELEASE;
                end
                // A still-high enable here is the old request, not a new one.
                RELEASE: if (!granted_en_d) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ctl_enable_o = ctl_enable_q;
    assign a_ack_o      = a_ack_q;
    assign b_ack_o      = b_ack_q;
    assign a_rd_data_o  = a_rd_q;
    assign b_rd_data_o  = b_rd_q;
    assign a_idle_o     = (state_q == IDLE) && ctl_idle_i;
    assign b_idle_o     = (state_q == IDLE) && ctl_idle_i;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a controller model that acks 3 cycles after enable.
module tb_sdram_arbiter;
    import sdram_arbiter_pkg::*;

    localparam logic [31:0] A_ST_ADDR = 32'h0000_A0A0;
    localparam logic [31:0] B_ST_ADDR = 32'h0000_B0B0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a_addr, b_addr, ctl_addr;
    logic [15:0] a_wr_data, b_wr_data, a_rd_data, b_rd_data, ctl_wr_data, ctl_rd_data;
    logic [1:0]  a_wr_mask, b_wr_mask, ctl_wr_mask;
    logic        a_we, b_we, a_en, b_en, a_ack, b_ack, a_idle, b_idle;
    logic        ctl_we, ctl_en, ctl_ack, ctl_idle;

    int  tests = 0, fails = 0;
    int  ack_cnt = 0, en_rises = 0, a_acks = 0, b_acks = 0, a_pre_b = 0;
    bit  inject = 0, starve = 0, b_seen = 0, b_done = 0, prev_en = 0;
    bit  to, to_a, to_b;
    int  gap, guard;

    always #5 clk = ~clk;

    sdram_arbiter #(.ADDR_BITS(32), .B_WAIT_LIMIT(8)) dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .a_addr_i(a_addr), .a_wr_data_i(a_wr_data), .a_wr_mask_i(a_wr_mask), .a_we_i(a_we),
        .a_enable_i(a_en), .a_ack_o(a_ack), .a_rd_data_o(a_rd_data), .a_idle_o(a_idle),
        .b_addr_i(b_addr), .b_wr_data_i(b_wr_data), .b_wr_mask_i(b_wr_mask), .b_we_i(b_we),
        .b_enable_i(b_en), .b_ack_o(b_ack), .b_rd_data_o(b_rd_data), .b_idle_o(b_idle),
        .ctl_addr_o(ctl_addr), .ctl_wr_data_o(ctl_wr_data), .ctl_wr_mask_o(ctl_wr_mask),
        .ctl_we_o(ctl_we), .ctl_enable_o(ctl_en), .ctl_rd_data_i(ctl_rd_data),
        .ctl_ack_i(ctl_ack), .ctl_idle_i(ctl_idle)
    );

    // Controller model: one-cycle ack on the 3rd negedge with enable high.
    always @(negedge clk) begin
        if (ctl_en && !ctl_ack) begin
            ack_cnt++;
            if (ack_cnt == 3) begin
                ctl_ack = 1'b1;
                ack_cnt = 0;
            end
        end else begin
            ctl_ack = inject;
            ack_cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (ctl_en && !prev_en) begin
            en_rises++;
            if (starve) begin
                if (ctl_addr == B_ST_ADDR) b_seen = 1;
                else if (!b_seen) a_pre_b++;
            end
        end
        prev_en = ctl_en;
        if (a_ack) a_acks++;
        if (b_ack) b_acks++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input bit is_b, output bit timed_out);
        timed_out = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (is_b ? b_ack : a_ack) begin
                timed_out = 0;
                break;
            end
        end
    endtask

    task automatic wait_en(output bit timed_out);
        timed_out = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ctl_en) begin
                timed_out = 0;
                break;
            end
        end
    endtask

    task automatic clr;
        en_rises = 0; a_acks = 0; b_acks = 0;
    endtask

    initial begin
        rst_n = 0; ctl_idle = 1; ctl_rd_data = 16'h0;
        a_addr = 0; a_wr_data = 0; a_wr_mask = 0; a_we = 0; a_en = 0;
        b_addr = 0; b_wr_data = 0; b_wr_mask = 0; b_we = 0; b_en = 0;
        repeat (2) @(negedge clk);
        chk("rst_ctl_en", 32'(ctl_en), 0);
        chk("rst_ctl_addr", ctl_addr, 0);
        chk("rst_ctl_wd", 32'(ctl_wr_data), 0);
        chk("rst_ctl_mask", 32'(ctl_wr_mask), 0);
        chk("rst_ctl_we", 32'(ctl_we), 0);
        chk("rst_acks", {30'd0, a_ack, b_ack}, 0);
        chk("rst_rd", {a_rd_data, b_rd_data}, 0);
        chk("rst_idle", {30'd0, a_idle, b_idle}, 32'd3);
        rst_n = 1;
        @(negedge clk);

        // A read; controller busy for the first cycles must hold it off
        clr();
        ctl_idle = 0; ctl_rd_data = 16'hBEEF;
        a_addr = 32'h0000_1234; a_we = 0; a_en = 1;
        repeat (3) @(negedge clk);
        chk("busy_ctl_no_grant", 32'(ctl_en), 0);
        chk("busy_ctl_a_idle", 32'(a_idle), 0);
        ctl_idle = 1;
        wait_en(to);
        chk("a_rd_en_timeout", 32'(to), 0);
        chk("a_rd_addr", ctl_addr, 32'h0000_1234);
        chk("a_rd_we", 32'(ctl_we), 0);
        wait_ack(0, to);
        chk("a_rd_ack_timeout", 32'(to), 0);
        chk("a_rd_data", 32'(a_rd_data), 32'hBEEF);
        a_en = 0;
        repeat (3) @(negedge clk);
        chk("a_rd_ack_once", a_acks, 1);
        chk("a_rd_no_b_ack", b_acks, 0);
        chk("a_rd_held", 32'(a_rd_data), 32'hBEEF);

        // B write
        clr();
        ctl_rd_data = 16'h5A5A;
        b_addr = 32'h5; b_wr_data = 16'hAB00; b_wr_mask = 2'b10; b_we = 1; b_en = 1;
        wait_en(to);
        chk("b_wr_en_timeout", 32'(to), 0);
        chk("b_wr_addr", ctl_addr, 32'h5);
        chk("b_wr_data", 32'(ctl_wr_data), 32'hAB00);
        chk("b_wr_mask", 32'(ctl_wr_mask), 32'h2);
        chk("b_wr_we", 32'(ctl_we), 1);
        wait_ack(1, to);
        chk("b_wr_ack_timeout", 32'(to), 0);
        chk("b_wr_rd_data", 32'(b_rd_data), 32'h5A5A);
        b_en = 0;
        repeat (3) @(negedge clk);
        chk("b_wr_ack_once", b_acks, 1);
        chk("b_wr_one_enable", en_rises, 1);
        chk("b_wr_no_a_ack", a_acks, 0);

        // Stray controller ack while idle is ignored
        clr();
        inject = 1;
        repeat (2) @(negedge clk);
        inject = 0;
        repeat (2) @(negedge clk);
        chk("stray_ack_ignored", a_acks + b_acks, 0);
        chk("stray_ack_state", 32'(dut.state_q), 32'(IDLE));

        // Simultaneous requests: A first, B right after A's release
        clr();
        a_addr = 32'h100; a_we = 0; b_addr = 32'h200; b_we = 0;
        a_en = 1; b_en = 1;
        wait_en(to);
        chk("sim_en_timeout", 32'(to), 0);
        chk("sim_first_is_a", ctl_addr, 32'h100);
        wait_ack(0, to);
        chk("sim_a_ack_timeout", 32'(to), 0);
        a_en = 0;
        gap = 0;
        wait_en(to);
        chk("sim_b_en_timeout", 32'(to), 0);
        chk("sim_second_is_b", ctl_addr, 32'h200);
        chk("sim_b_state", 32'(dut.state_q), 32'(BUSY_B));
        wait_ack(1, to);
        chk("sim_b_ack_timeout", 32'(to), 0);
        b_en = 0;
        repeat (3) @(negedge clk);
        chk("sim_two_grants", en_rises, 2);

        // Starvation: A re-requests back to back while B waits
        clr();
        a_addr = A_ST_ADDR; b_addr = B_ST_ADDR;
        starve = 1; b_seen = 0; b_done = 0; a_pre_b = 0; guard = 0;
        fork
            begin
                b_en = 1;
                wait_ack(1, to_b);
                b_en = 0;
                b_done = 1;
            end
            begin
                while (!b_done && guard < 20) begin
                    a_en = 1;
                    wait_ack(0, to_a);
                    a_en = 0;
                    @(negedge clk);
                    guard++;
                end
            end
        join
        repeat (3) @(negedge clk);
        starve = 0;
        chk("starve_b_timeout", 32'(to_b), 0);
        chk("starve_a_timeout", 32'(to_a), 0);
        chk("starve_b_granted", 32'(b_seen), 1);
        chk("starve_a_before_b", a_pre_b, 8);
        chk("starve_wait_cleared", 32'(dut.b_wait_q), 0);

        // Client holds enable past its ack
        clr();
        a_addr = 32'h300; a_en = 1;
        wait_ack(0, to);
        chk("hold_ack_timeout", 32'(to), 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_in_release", 32'(dut.state_q), 32'(RELEASE));
            chk("hold_no_enable", 32'(ctl_en), 0);
        end
        a_en = 0;
        repeat (3) @(negedge clk);
        chk("hold_one_grant", en_rises, 1);
        chk("hold_back_idle", 32'(dut.state_q), 32'(IDLE));

        // Reset in the middle of a B transfer
        clr();
        ctl_rd_data = 16'hDEAD;
        b_addr = 32'h400; b_wr_data = 16'h1111; b_wr_mask = 2'b01; b_we = 1; b_en = 1;
        wait_en(to);
        chk("rst_b_en_timeout", 32'(to), 0);
        chk("rst_b_busy", 32'(dut.state_q), 32'(BUSY_B));
        #2 rst_n = 0;
        #1;
        chk("mid_rst_ctl_en", 32'(ctl_en), 0);
        chk("mid_rst_ctl_addr", ctl_addr, 0);
        chk("mid_rst_ctl_fields", {13'd0, ctl_wr_data, ctl_wr_mask, ctl_we}, 0);
        chk("mid_rst_rd", {a_rd_data, b_rd_data}, 0);
        chk("mid_rst_acks", {30'd0, a_ack, b_ack}, 0);
        @(negedge clk);
        b_en = 0;
        rst_n = 1;
        repeat (6) @(negedge clk);
        chk("mid_rst_no_b_ack", b_acks, 0);
        ctl_rd_data = 16'h1357;
        a_addr = 32'h77; a_we = 0; a_en = 1;
        wait_en(to);
        chk("post_rst_en_timeout", 32'(to), 0);
        chk("post_rst_addr", ctl_addr, 32'h77);
        wait_ack(0, to);
        chk("post_rst_ack_timeout", 32'(to), 0);
        chk("post_rst_rd", 32'(a_rd_data), 32'h1357);
        a_en = 0;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", {30'd0, a_idle, b_idle}, 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
